proc_in_debounce_multi: RTL and testbench

Multi-channel, counter-based input debouncer for the DIOB processing plugin chain. It sits between the physical-side input path (internal_in) and the virtual/system side (virtual_in). Each channel gets a configurable synchroniser, a configurable stable-time counter, an optional inversion, and a selectable output mode (level or one-cycle edge pulse). A sticky per-channel flag records rejected glitches. The output path passes through unchanged.

---
 rtl/proc_in_debounce_multi.sv | 91 +++++++++
 tb/tb_proc_in_debounce_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/proc_in_debounce_multi.sv
// rtl/proc_in_debounce_multi.sv - multi-channel counter-based input debouncer with glitch flags
module proc_in_debounce_multi #(
  parameter int nr_channels    = 8,
  parameter int cnt_width      = 8,
  parameter int debounce_ticks = 16,
  parameter int sync_stages    = 2,
  parameter int out_mode       = 0,
  parameter bit invert         = 1'b0,
  parameter bit init_value     = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nr_channels-1:0] internal_in,
  input  logic [nr_channels-1:0] virtual_out,
  input  logic [nr_channels-1:0] glitch_clear,
  output logic [nr_channels-1:0] internal_out,
  output logic [nr_channels-1:0] virtual_in,
  output logic [nr_channels-1:0] db_state,
  output logic [nr_channels-1:0] glitch_flag,
  output logic                   output_enable,
  output logic                   input_enable
);

  if (debounce_ticks < 1 || 64'(debounce_ticks) > (64'd1 << cnt_width) || sync_stages < 1) begin : g_param_check
    $error("proc_in_debounce_multi: illegal debounce_ticks/cnt_width/sync_stages");
  end

  localparam logic [nr_channels-1:0] init_vec = {nr_channels{init_value}};
  localparam logic [cnt_width-1:0]   last_cnt = cnt_width'(debounce_ticks - 1);

  logic [nr_channels-1:0] sync_q [sync_stages];
  logic [nr_channels-1:0] s;
  logic [nr_channels-1:0] pulse;

  assign s             = sync_q[sync_stages-1];
  assign internal_out  = virtual_out;
  assign output_enable = 1'b1;
  assign input_enable  = 1'b1;
  assign virtual_in    = (out_mode == 0) ? db_state : pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < sync_stages; i++) sync_q[i] <= init_vec;
    end else begin
      sync_q[0] <= internal_in ^ {nr_channels{invert}};
      for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar c = 0; c < nr_channels; c++) begin : g_ch
    logic [cnt_width-1:0] cnt;
    logic                 db_q;
    logic                 glitch_q;
    logic                 pulse_q;
    logic                 differs;
    logic                 accept;
    logic                 edge_wanted;

    assign differs = s[c] != db_q;
    assign accept  = differs && (cnt == last_cnt);
    // s[c] is the level about to be accepted, so it tells rising from falling
    assign edge_wanted = (out_mode == 1) ? s[c] :
                         (out_mode == 2) ? !s[c] :
                         (out_mode == 3);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        db_q     <= init_value;
        glitch_q <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        if (!differs || accept) cnt <= '0;
        else                    cnt <= cnt + cnt_width'(1);

        if (accept) db_q <= s[c];

        // a pending change that collapses back is a rejected glitch; set beats clear
        if (!differs && cnt != '0) glitch_q <= 1'b1;
        else if (glitch_clear[c])  glitch_q <= 1'b0;

        pulse_q <= accept && edge_wanted;
      end
    end

    assign db_state[c]    = db_q;
    assign glitch_flag[c] = glitch_q;
    assign pulse[c]       = pulse_q;
  end

endmodule

// File: tb/tb_proc_in_debounce_multi.sv
// tb/tb_proc_in_debounce_multi.sv - directed self-checking bench for proc_in_debounce_multi
module tb_proc_in_debounce_multi;

  logic clock;
  logic reset;
  logic [7:0] def_in, m_in, inv_in, fast_in, vo, clr, zero_v;

  logic [7:0] def_io, def_vi, def_db, def_gf;
  logic [7:0] m3_io, m3_vi, m3_db, m3_gf;
  logic [7:0] m1_io, m1_vi, m1_db, m1_gf;
  logic [7:0] inv_io, inv_vi, inv_db, inv_gf;
  logic [7:0] fast_io, fast_vi, fast_db, fast_gf;
  logic def_oe, def_ie, m3_oe, m3_ie, m1_oe, m1_ie, inv_oe, inv_ie, fast_oe, fast_ie;

  int total;
  int bad;
  logic [7:0] h1, h2;

  proc_in_debounce_multi u_def (
    .clock(clock), .reset(reset), .internal_in(def_in), .virtual_out(vo), .glitch_clear(clr),
    .internal_out(def_io), .virtual_in(def_vi), .db_state(def_db), .glitch_flag(def_gf),
    .output_enable(def_oe), .input_enable(def_ie));

  proc_in_debounce_multi #(.debounce_ticks(4), .out_mode(3)) u_m3 (
    .clock(clock), .reset(reset), .internal_in(m_in), .virtual_out(vo), .glitch_clear(zero_v),
    .internal_out(m3_io), .virtual_in(m3_vi), .db_state(m3_db), .glitch_flag(m3_gf),
    .output_enable(m3_oe), .input_enable(m3_ie));

  proc_in_debounce_multi #(.debounce_ticks(4), .out_mode(1)) u_m1 (
    .clock(clock), .reset(reset), .internal_in(m_in), .virtual_out(vo), .glitch_clear(zero_v),
    .internal_out(m1_io), .virtual_in(m1_vi), .db_state(m1_db), .glitch_flag(m1_gf),
    .output_enable(m1_oe), .input_enable(m1_ie));

  proc_in_debounce_multi #(.invert(1'b1), .init_value(1'b1)) u_inv (
    .clock(clock), .reset(reset), .internal_in(inv_in), .virtual_out(vo), .glitch_clear(zero_v),
    .internal_out(inv_io), .virtual_in(inv_vi), .db_state(inv_db), .glitch_flag(inv_gf),
    .output_enable(inv_oe), .input_enable(inv_ie));

  proc_in_debounce_multi #(.debounce_ticks(1), .sync_stages(1)) u_fast (
    .clock(clock), .reset(reset), .internal_in(fast_in), .virtual_out(vo), .glitch_clear(zero_v),
    .internal_out(fast_io), .virtual_in(fast_vi), .db_state(fast_db), .glitch_flag(fast_gf),
    .output_enable(fast_oe), .input_enable(fast_ie));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    def_in = '0; m_in = '0; inv_in = '0; fast_in = '0; vo = '0; clr = '0; zero_v = '0;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_def_db", def_db, 8'h00);
    check("rst_def_vi", def_vi, 8'h00);
    check("rst_def_gf", def_gf, 8'h00);
    check("rst_enables", {6'd0, def_oe, def_ie}, 8'h03);
    check("rst_inv_db", inv_db, 8'hff);
    check("rst_inv_vi", inv_vi, 8'hff);
    check("rst_m3_vi", m3_vi, 8'h00);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("rel_inv_db", inv_db, 8'hff);
      check("rel_m3_vi", m3_vi, 8'h00);
      check("rel_m1_vi", m1_vi, 8'h00);
    end

    // ch0 rise on defaults, ch3 on inverted instance: both land after 18 edges
    def_in[0] = 1'b1;
    inv_in[3] = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clock);
      if (i == 17) begin
        check("t1_db_early", def_db, 8'h00);
        check("t4_db_early", inv_db, 8'hff);
      end
      if (i == 18) begin
        check("t1_db", def_db, 8'h01);
        check("t1_vi", def_vi, 8'h01);
        check("t4_db", inv_db, 8'hf7);
        check("t4_vi", inv_vi, 8'hf7);
      end
    end

    // 15-clock pulse on ch1 is rejected and flagged
    def_in[1] = 1'b1;
    repeat (15) @(negedge clock);
    def_in[1] = 1'b0;
    repeat (5) @(negedge clock);
    check("t2_db", def_db, 8'h01);
    check("t2_gf", def_gf, 8'h02);
    clr[1] = 1'b1;
    @(negedge clock);
    clr[1] = 1'b0;
    check("t2_gf_clr", def_gf, 8'h00);

    // glitch lands on edge 18; clear held across that same edge
    def_in[1] = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clock);
      if (i == 15) def_in[1] = 1'b0;
      if (i == 17) begin
        check("t2_gf_pre", def_gf, 8'h00);
        clr[1] = 1'b1;
      end
      if (i == 18) begin
        clr[1] = 1'b0;
        check("t2_gf_set_wins", def_gf, 8'h02);
        check("t2_db_held", def_db, 8'h01);
      end
    end

    // edge pulses: ticks=4, sync=2 -> change visible 6 edges after the first sample
    m_in[2] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      check("t3_m3_vi", m3_vi, (i == 6 || i == 16) ? 8'h04 : 8'h00);
      check("t3_m1_vi", m1_vi, (i == 6) ? 8'h04 : 8'h00);
      check("t3_m3_db", m3_db, (i >= 6 && i < 16) ? 8'h04 : 8'h00);
      if (i == 10) m_in[2] = 1'b0;
    end

    // asynchronous reset with ch4 counter at 10
    def_in[4] = 1'b1;
    repeat (12) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t5_db_async", def_db, 8'h00);
    check("t5_vi_async", def_vi, 8'h00);
    check("t5_gf_async", def_gf, 8'h00);
    check("t5_inv_db_async", inv_db, 8'hff);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clock);
      check("t5_m3_vi", m3_vi, 8'h00);
      if (i == 17) check("t5_db_early", def_db, 8'h00);
      if (i == 18) check("t5_db", def_db, 8'h11);
    end

    // ticks=1, sync=1: db_state is internal_in delayed two edges; pass-through path
    h1 = '0; h2 = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      check("t6_db", fast_db, h2);
      fast_in = 8'($urandom);
      vo      = 8'($urandom);
      h2 = h1;
      h1 = fast_in;
      #1;
      check("t6_pass_fast", fast_io, vo);
      check("t6_pass_def", def_io, vo);
      check("t6_gf", fast_gf, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
